// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle controller and the datapath.
// The master side is the controller: it reads the instruction fields, the
// ALU zero flag and the memory ready strobe, and drives every select/enable.
//
// Memory handshake: MemRead/MemWrite act as the request (valid) and are held
// high continuously until the cycle in which mem_ready is 1. That cycle is
// the transfer cycle. The request drops, or moves to the next access, in the
// following cycle. mem_ready is ignored whenever no request is asserted.
interface multicycle_ctrl_if #(
  parameter int ALUOP_W = 4
);
  logic [5:0]         OpCode;
  logic [5:0]         Funct;
  logic               Zero;
  logic               mem_ready;

  logic               PCWrite;
  logic               PCWriteCond;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic [1:0]         MemtoReg;
  logic [1:0]         RegDst;
  logic               RegWrite;
  logic               ExtOp;
  logic               LuiOp;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [ALUOP_W-1:0] ALUOp;
  logic [1:0]         PCSource;
  logic               instr_done;
  logic               illegal;

  modport master (
    input  OpCode, Funct, Zero, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ExtOp, LuiOp, ALUSrcA, ALUSrcB,
           ALUOp, PCSource, instr_done, illegal
  );

  modport slave (
    output OpCode, Funct, Zero, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ExtOp, LuiOp, ALUSrcA, ALUSrcB,
           ALUOp, PCSource, instr_done, illegal
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS CPU. Sequences IF/ID/EX/MEM/WB
// for each instruction and drives every datapath select and enable. Outputs
// are combinational from the current state and the decoded instruction, and
// they are forced to zero in any cycle where reset is low.
// Debug outputs: 'state' exposes the FSM state. 'pc_load' is the effective
// PC load, which is PCWrite, or PCWriteCond qualified by the Zero flag.
module multicycle_ctrl #(
  parameter int STATE_W = 3,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.master  bus,
  output logic [STATE_W-1:0] state,
  output logic               pc_load
);

  typedef enum logic [STATE_W-1:0] {
    S_IF,
    S_ID,
    S_EX,
    S_MEM,
    S_WB
  } state_t;

  typedef enum logic [3:0] {
    C_R,
    C_JR,
    C_LW,
    C_SW,
    C_IALU,
    C_LUI,
    C_BEQ,
    C_J,
    C_JAL,
    C_ILL
  } cls_t;

  // Opcodes
  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type function codes
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2a;
  localparam logic [5:0] F_SLTU = 6'h2b;

  // ALUOp classes understood by ALU control
  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_RFN  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(6);

  state_t             cur_state;
  state_t             nxt_state;
  cls_t               cls;
  logic [ALUOP_W-1:0] imm_alu_op;
  logic               ext_op;
  logic               lui_op;
  logic               ext_sel;

  // Ungated control values, before the reset gate is applied
  logic               pc_write;
  logic               pc_write_cond;
  logic               i_or_d;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic [1:0]         mem_to_reg;
  logic [1:0]         reg_dst;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic [1:0]         pc_source;
  logic               done;
  logic               bad_op;

  // Classify the instruction and pick the ALU class for immediate ops
  always_comb begin
    cls        = C_ILL;
    imm_alu_op = ALU_ADD;
    case (bus.OpCode)
      OP_R: begin
        case (bus.Funct)
          F_JR:                                    cls = C_JR;
          F_SLL, F_SRL, F_SRA,
          F_ADD, F_ADDU, F_SUB, F_SUBU,
          F_AND, F_OR, F_XOR, F_NOR,
          F_SLT, F_SLTU:                           cls = C_R;
          default:                                 cls = C_ILL;
        endcase
      end
      OP_LW:              cls = C_LW;
      OP_SW:              cls = C_SW;
      OP_ADDI, OP_ADDIU:  cls = C_IALU;
      OP_SLTI: begin
        cls        = C_IALU;
        imm_alu_op = ALU_SLT;
      end
      OP_SLTIU: begin
        cls        = C_IALU;
        imm_alu_op = ALU_SLTU;
      end
      OP_ANDI: begin
        cls        = C_IALU;
        imm_alu_op = ALU_AND;
      end
      OP_ORI: begin
        cls        = C_IALU;
        imm_alu_op = ALU_OR;
      end
      // lui has rs = $0, so an add passes the shifted immediate through
      OP_LUI:             cls = C_LUI;
      OP_BEQ:             cls = C_BEQ;
      OP_J:               cls = C_J;
      OP_JAL:             cls = C_JAL;
      default:            cls = C_ILL;
    endcase
  end

  // Logical immediates are zero-extended. Everything else is sign-extended.
  assign ext_op = !((bus.OpCode == OP_ANDI) || (bus.OpCode == OP_ORI));
  assign lui_op = (bus.OpCode == OP_LUI);

  // State register; reset forces a fresh fetch
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_state <= S_IF;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state and per-state control decode
  always_comb begin
    nxt_state     = S_IF;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 2'd0;
    reg_dst       = 2'd0;
    reg_write     = 1'b0;
    ext_sel       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = ALU_ADD;
    pc_source     = 2'd0;
    done          = 1'b0;
    bad_op        = 1'b0;
    case (cur_state)
      S_IF: begin
        // PC + 4 is computed while the fetch is outstanding
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        if (bus.mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          nxt_state = S_ID;
        end else begin
          nxt_state = S_IF;
        end
      end
      S_ID: begin
        // Branch target PC + (imm << 2) is parked in ALUOut speculatively
        ext_sel   = 1'b1;
        alu_src_b = 2'd3;
        case (cls)
          C_J: begin
            pc_write  = 1'b1;
            pc_source = 2'd2;
            done      = 1'b1;
            nxt_state = S_IF;
          end
          C_JAL: begin
            pc_write   = 1'b1;
            pc_source  = 2'd2;
            reg_write  = 1'b1;
            reg_dst    = 2'd2;
            mem_to_reg = 2'd2;
            done       = 1'b1;
            nxt_state  = S_IF;
          end
          C_ILL: begin
            bad_op    = 1'b1;
            done      = 1'b1;
            nxt_state = S_IF;
          end
          default: nxt_state = S_EX;
        endcase
      end
      S_EX: begin
        ext_sel   = 1'b1;
        alu_src_a = 1'b1;
        case (cls)
          C_R: begin
            alu_op    = ALU_RFN;
            nxt_state = S_WB;
          end
          C_JR: begin
            alu_op    = ALU_RFN;
            pc_write  = 1'b1;
            pc_source = 2'd3;
            done      = 1'b1;
            nxt_state = S_IF;
          end
          C_IALU, C_LUI: begin
            alu_src_b = 2'd2;
            alu_op    = imm_alu_op;
            nxt_state = S_WB;
          end
          C_LW, C_SW: begin
            alu_src_b = 2'd2;
            nxt_state = S_MEM;
          end
          C_BEQ: begin
            alu_op        = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_source     = 2'd1;
            done          = 1'b1;
            nxt_state     = S_IF;
          end
          default: nxt_state = S_IF;
        endcase
      end
      S_MEM: begin
        // Request is held until the memory reports completion
        ext_sel   = 1'b1;
        i_or_d    = 1'b1;
        mem_read  = (cls == C_LW);
        mem_write = (cls == C_SW);
        if ((cls != C_LW) && (cls != C_SW)) begin
          nxt_state = S_IF;
        end else if (!bus.mem_ready) begin
          nxt_state = S_MEM;
        end else if (cls == C_LW) begin
          nxt_state = S_WB;
        end else begin
          done      = 1'b1;
          nxt_state = S_IF;
        end
      end
      S_WB: begin
        ext_sel   = 1'b1;
        reg_write = 1'b1;
        done      = 1'b1;
        nxt_state = S_IF;
        if (cls == C_LW) begin
          mem_to_reg = 2'd1;
        end else if (cls == C_R) begin
          reg_dst = 2'd1;
        end
      end
      default: nxt_state = S_IF;
    endcase
  end

  // While reset is low, every output is forced to 0. This also aborts any write in that cycle.
  assign bus.PCWrite     = reset & pc_write;
  assign bus.PCWriteCond = reset & pc_write_cond;
  assign bus.IorD        = reset & i_or_d;
  assign bus.MemRead     = reset & mem_read;
  assign bus.MemWrite    = reset & mem_write;
  assign bus.IRWrite     = reset & ir_write;
  assign bus.MemtoReg    = reset ? mem_to_reg : 2'd0;
  assign bus.RegDst      = reset ? reg_dst : 2'd0;
  assign bus.RegWrite    = reset & reg_write;
  assign bus.ExtOp       = reset & ext_sel & ext_op;
  assign bus.LuiOp       = reset & ext_sel & lui_op;
  assign bus.ALUSrcA     = reset & alu_src_a;
  assign bus.ALUSrcB     = reset ? alu_src_b : 2'd0;
  assign bus.ALUOp       = reset ? alu_op : '0;
  assign bus.PCSource    = reset ? pc_source : 2'd0;
  assign bus.instr_done  = reset & done;
  assign bus.illegal     = reset & bad_op;

  assign state   = cur_state;
  assign pc_load = reset & (pc_write | (pc_write_cond & bus.Zero));

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for the multi-cycle MIPS control FSM.
module tb_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic [2:0] state;
  logic       pc_load;
  int         n_cmp;
  int         n_bad;
  int         cyc_n;
  logic [14:0] trace;
  int         mr_cnt;
  int         ir_cnt;
  logic [23:0] ctl;

  multicycle_ctrl_if #(.ALUOP_W(4)) bus ();

  multicycle_ctrl #(.STATE_W(3), .ALUOP_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state   (state),
    .pc_load (pc_load)
  );

  // All controls packed together, so the reset state can be checked at once
  assign ctl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst,
                bus.RegWrite, bus.ExtOp, bus.LuiOp, bus.ALUSrcA,
                bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.instr_done,
                bus.illegal};

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic rdy);
    bus.OpCode    = op;
    bus.Funct     = fn;
    bus.Zero      = z;
    bus.mem_ready = rdy;
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one instruction from IF to its done pulse, with a bounded number of cycles
  task automatic run_instr(output int cycles, output logic [14:0] tr);
    cycles = 0;
    tr     = '0;
    for (int k = 0; k < 20; k++) begin
      tr = {tr[11:0], state};
      cycles++;
      if (bus.instr_done) begin
        tick();
        return;
      end
      tick();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    set_in(6'h00, 6'h00, 1'b0, 1'b1);

    // Reset: outputs gated low even with mem_ready high
    tick();
    check("rst_state", state, 3'd0);
    check("rst_ctl", ctl, 24'h0);
    check("rst_pcload", pc_load, 1'b0);

    // lw, stepped one state at a time
    reset = 1'b1;
    set_in(6'h23, 6'h00, 1'b0, 1'b1);
    check("lw_if_state", state, 3'd0);
    check("lw_if_memread", bus.MemRead, 1'b1);
    check("lw_if_irwrite", bus.IRWrite, 1'b1);
    check("lw_if_pcwrite", bus.PCWrite, 1'b1);
    check("lw_if_srcb", bus.ALUSrcB, 2'd1);
    check("lw_if_extop", bus.ExtOp, 1'b0);
    tick();
    check("lw_id_state", state, 3'd1);
    check("lw_id_srcb", bus.ALUSrcB, 2'd3);
    check("lw_id_extop", bus.ExtOp, 1'b1);
    tick();
    check("lw_ex_state", state, 3'd2);
    check("lw_ex_srca", bus.ALUSrcA, 1'b1);
    check("lw_ex_srcb", bus.ALUSrcB, 2'd2);
    check("lw_ex_aluop", bus.ALUOp, 4'd0);
    tick();
    check("lw_mem_state", state, 3'd3);
    check("lw_mem_iord", bus.IorD, 1'b1);
    check("lw_mem_memread", bus.MemRead, 1'b1);
    tick();
    check("lw_wb_state", state, 3'd4);
    check("lw_wb_regwrite", bus.RegWrite, 1'b1);
    check("lw_wb_memtoreg", bus.MemtoReg, 2'd1);
    check("lw_wb_regdst", bus.RegDst, 2'd0);
    check("lw_wb_done", bus.instr_done, 1'b1);
    tick();

    // lw latency and state trace
    run_instr(cyc_n, trace);
    check("lw_cycles", cyc_n, 5);
    check("lw_trace", trace, 15'o01234);

    // ori: zero-extended immediate, OR class
    set_in(6'h0d, 6'h00, 1'b0, 1'b1);
    tick();
    tick();
    check("ori_ex_extop", bus.ExtOp, 1'b0);
    check("ori_ex_luiop", bus.LuiOp, 1'b0);
    check("ori_ex_aluop", bus.ALUOp, 4'd4);
    check("ori_ex_srcb", bus.ALUSrcB, 2'd2);
    tick();
    check("ori_wb_regdst", bus.RegDst, 2'd0);
    check("ori_wb_done", bus.instr_done, 1'b1);
    tick();

    // addi: sign-extended immediate
    set_in(6'h08, 6'h00, 1'b0, 1'b1);
    tick();
    check("addi_id_extop", bus.ExtOp, 1'b1);
    tick();
    check("addi_ex_aluop", bus.ALUOp, 4'd0);
    tick();
    tick();

    // lui: LuiOp held through EX and WB
    set_in(6'h0f, 6'h00, 1'b0, 1'b1);
    tick();
    tick();
    check("lui_ex_luiop", bus.LuiOp, 1'b1);
    tick();
    check("lui_wb_luiop", bus.LuiOp, 1'b1);
    check("lui_wb_regdst", bus.RegDst, 2'd0);
    check("lui_wb_regwrite", bus.RegWrite, 1'b1);
    check("lui_wb_done", bus.instr_done, 1'b1);
    tick();
    run_instr(cyc_n, trace);
    check("lui_cycles", cyc_n, 4);
    check("lui_trace", trace, 15'o00124);

    // Fetch stalled 3 cycles, then R-type add
    set_in(6'h00, 6'h20, 1'b0, 1'b0);
    mr_cnt = 0;
    ir_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      check("stall_state", state, 3'd0);
      check("stall_pcwrite", bus.PCWrite, 1'b0);
      mr_cnt += int'(bus.MemRead);
      ir_cnt += int'(bus.IRWrite);
      tick();
    end
    bus.mem_ready = 1'b1;
    #1;
    mr_cnt += int'(bus.MemRead);
    ir_cnt += int'(bus.IRWrite);
    tick();
    check("stall_memread_cnt", mr_cnt, 4);
    check("stall_irwrite_cnt", ir_cnt, 1);
    check("add_id_state", state, 3'd1);
    tick();
    check("add_ex_srcb", bus.ALUSrcB, 2'd0);
    check("add_ex_aluop", bus.ALUOp, 4'd2);
    tick();
    check("add_wb_regdst", bus.RegDst, 2'd1);
    check("add_wb_regwrite", bus.RegWrite, 1'b1);
    tick();
    run_instr(cyc_n, trace);
    check("add_cycles", cyc_n, 4);
    check("add_trace", trace, 15'o00124);

    // beq taken
    set_in(6'h04, 6'h00, 1'b1, 1'b1);
    tick();
    tick();
    check("beq1_ex_cond", bus.PCWriteCond, 1'b1);
    check("beq1_ex_pcsrc", bus.PCSource, 2'd1);
    check("beq1_ex_aluop", bus.ALUOp, 4'd1);
    check("beq1_ex_done", bus.instr_done, 1'b1);
    check("beq1_pcload", pc_load, 1'b1);
    tick();

    // beq not taken
    set_in(6'h04, 6'h00, 1'b0, 1'b1);
    tick();
    tick();
    check("beq0_ex_cond", bus.PCWriteCond, 1'b1);
    check("beq0_ex_pcsrc", bus.PCSource, 2'd1);
    check("beq0_pcload", pc_load, 1'b0);
    tick();
    run_instr(cyc_n, trace);
    check("beq_cycles", cyc_n, 3);
    check("beq_trace", trace, 15'o00012);

    // jal: link into $31 and jump from ID
    set_in(6'h03, 6'h00, 1'b0, 1'b1);
    tick();
    check("jal_id_regdst", bus.RegDst, 2'd2);
    check("jal_id_memtoreg", bus.MemtoReg, 2'd2);
    check("jal_id_regwrite", bus.RegWrite, 1'b1);
    check("jal_id_pcsrc", bus.PCSource, 2'd2);
    check("jal_id_pcwrite", bus.PCWrite, 1'b1);
    check("jal_id_done", bus.instr_done, 1'b1);
    tick();
    check("jal_back_if", state, 3'd0);

    // j, jr, sw latencies
    set_in(6'h02, 6'h00, 1'b0, 1'b1);
    run_instr(cyc_n, trace);
    check("j_cycles", cyc_n, 2);
    check("j_trace", trace, 15'o00001);
    set_in(6'h00, 6'h08, 1'b0, 1'b1);
    tick();
    tick();
    check("jr_ex_pcsrc", bus.PCSource, 2'd3);
    check("jr_ex_pcwrite", bus.PCWrite, 1'b1);
    check("jr_ex_regwrite", bus.RegWrite, 1'b0);
    tick();
    run_instr(cyc_n, trace);
    check("jr_cycles", cyc_n, 3);
    set_in(6'h2b, 6'h00, 1'b0, 1'b1);
    run_instr(cyc_n, trace);
    check("sw_cycles", cyc_n, 4);
    check("sw_trace", trace, 15'o00123);

    // Illegal opcode and illegal funct
    set_in(6'h3f, 6'h00, 1'b0, 1'b1);
    tick();
    check("ill_op_pulse", bus.illegal, 1'b1);
    check("ill_op_done", bus.instr_done, 1'b1);
    check("ill_op_regwrite", bus.RegWrite, 1'b0);
    tick();
    check("ill_op_back_if", state, 3'd0);
    check("ill_op_clear", bus.illegal, 1'b0);
    set_in(6'h00, 6'h01, 1'b0, 1'b1);
    tick();
    check("ill_fn_pulse", bus.illegal, 1'b1);
    tick();
    check("ill_fn_back_if", state, 3'd0);

    // sw stalled in MEM, then aborted by reset
    set_in(6'h2b, 6'h00, 1'b0, 1'b1);
    tick();
    tick();
    tick();
    bus.mem_ready = 1'b0;
    #1;
    check("swr_mem_state", state, 3'd3);
    check("swr_memwrite", bus.MemWrite, 1'b1);
    check("swr_iord", bus.IorD, 1'b1);
    tick();
    check("swr_memwrite_held", bus.MemWrite, 1'b1);
    check("swr_done_low", bus.instr_done, 1'b0);
    reset = 1'b0;
    #1;
    check("swr_rst_memwrite", bus.MemWrite, 1'b0);
    check("swr_rst_ctl", ctl, 24'h0);
    tick();
    check("swr_rst_state", state, 3'd0);
    reset = 1'b1;
    #1;
    check("swr_refetch_state", state, 3'd0);
    check("swr_refetch_memread", bus.MemRead, 1'b1);
    check("swr_refetch_irwrite", bus.IRWrite, 1'b0);
    tick();
    check("swr_refetch_hold", state, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
